// File: rtl/uart_loop_fifo_if.sv
// uart_loop_fifo_if
// Groups the receive strobe/data, transmitter handshake and FIFO status
// signals of the UART loopback FIFO.
//   slave  : the loopback block (consumes receive/tx_busy, drives send/status)
//   master : the environment (drives receive/tx_busy, observes send/status)
// Signals:
//   recv_done  receiver byte-done strobe (rising edge = new byte)
//   recv_data  received byte, valid while recv_done is high
//   tx_busy    transmitter busy while a frame is on the line
//   send_en    one-cycle transmit request
//   send_data  byte to transmit
//   fifo_count number of stored bytes (0..2^DEPTH_LOG2)
//   fifo_empty high when no bytes are stored
//   overflow   sticky: a byte was dropped because the FIFO was full
interface uart_loop_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  recv_done;
    logic [7:0]            recv_data;
    logic                  tx_busy;
    logic                  send_en;
    logic [7:0]            send_data;
    logic [DEPTH_LOG2:0]   fifo_count;
    logic                  fifo_empty;
    logic                  overflow;

    modport slave (
        input  recv_done,
        input  recv_data,
        input  tx_busy,
        output send_en,
        output send_data,
        output fifo_count,
        output fifo_empty,
        output overflow
    );

    modport master (
        output recv_done,
        output recv_data,
        output tx_busy,
        input  send_en,
        input  send_data,
        input  fifo_count,
        input  fifo_empty,
        input  overflow
    );
endinterface

// File: rtl/uart_loop_fifo.sv
// uart_loop_fifo
// Buffers bytes arriving from a UART receiver in a 2^DEPTH_LOG2-entry FIFO
// and feeds them one at a time to a UART transmitter.
// Ports:
//   clk      system clock, all logic on its rising edge
//   sys_rst  synchronous active-high reset
//   bus      uart_loop_fifo_if.slave (receive strobe/data, tx handshake,
//            FIFO status)
// Parameters:
//   DEPTH_LOG2    log2 of FIFO depth
//   BUSY_TIMEOUT  cycles to wait for tx_busy to rise after a launch before
//                 treating the byte as sent
module uart_loop_fifo #(
    parameter int DEPTH_LOG2   = 4,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            sys_rst,
    uart_loop_fifo_if.slave bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int TW    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [TW-1:0]       TMO_LAST = TW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t                state_q;
    logic [TW-1:0]         timer_q;
    logic [7:0]            send_data_q;
    logic [7:0]            mem_q [DEPTH];
    logic                  recv_done_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  empty_q;
    logic                  overflow_q, overflow_d;

    logic push_s;
    logic pop_s;
    logic full_s;
    logic accept_s;

    assign push_s   = bus.recv_done & ~recv_done_q;
    assign full_s   = (count_q == FULL_CNT);
    assign pop_s    = (state_q == IDLE) && (count_q != '0) && !bus.tx_busy;
    // A pop in the same cycle frees a slot, so a push at full still lands.
    assign accept_s = push_s && (!full_s || pop_s);

    // FIFO pointer, occupancy and overflow next-state
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (accept_s) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({accept_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (push_s && !accept_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // FIFO control registers and recv_done history
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            recv_done_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
        end else begin
            recv_done_q <= bus.recv_done;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            empty_q     <= (count_d == '0);
            overflow_q  <= overflow_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers gate validity
    always_ff @(posedge clk) begin
        if (accept_s && !sys_rst) begin
            mem_q[wr_ptr_q] <= bus.recv_data;
        end
    end

    // Send FSM: pop, one-cycle launch, wait for busy to rise, wait for done
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            send_data_q <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop_s) begin
                        send_data_q <= mem_q[rd_ptr_q];
                        state_q     <= LAUNCH;
                    end else begin
                        state_q     <= IDLE;
                    end
                end
                LAUNCH: begin
                    timer_q <= '0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (timer_q == TMO_LAST) begin
                        // Transmitter never acknowledged; drop it as sent.
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        state_q <= IDLE;
                    end else begin
                        state_q <= WAIT_DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.send_en    = (state_q == LAUNCH);
    assign bus.send_data  = send_data_q;
    assign bus.fifo_count = count_q;
    assign bus.fifo_empty = empty_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_uart_loop_fifo.sv
// tb_uart_loop_fifo
// Self-checking bench for uart_loop_fifo. A queue-based reference model
// tracks accepted bytes, occupancy and the sticky overflow flag; a simple
// transmitter model drives tx_busy (low, held high, or 20 cycles per byte).
module tb_uart_loop_fifo;

    logic clk;
    logic sys_rst;

    uart_loop_fifo_if #(.DEPTH_LOG2(4)) bus ();

    uart_loop_fifo #(
        .DEPTH_LOG2  (4),
        .BUSY_TIMEOUT(8)
    ) dut (
        .clk    (clk),
        .sys_rst(sys_rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    // reference model state
    logic [7:0] exp_q[$];
    logic [7:0] sent_q[$];
    int         pulse_cyc[$];
    int         level     = 0;
    bit         prev_rd   = 1'b0;
    bit         model_ovf = 1'b0;
    int         pulses    = 0;
    int         cyc       = 0;
    // transmitter model: 0 = idle low, 1 = held high, 2 = 20 cycles per byte
    int         tx_mode   = 0;
    int         busy_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic       rd;
        logic       rst_now;
        logic [7:0] d;
        bit         popped;
        rd      = bus.recv_done;
        rst_now = sys_rst;
        d       = bus.recv_data;
        @(posedge clk);
        #1;
        cyc++;
        popped = 1'b0;
        if (rst_now) begin
            level     = 0;
            prev_rd   = 1'b0;
            model_ovf = 1'b0;
            exp_q.delete();
        end else begin
            popped = bus.send_en;
            if (popped) begin
                sent_q.push_back(bus.send_data);
                pulse_cyc.push_back(cyc);
                pulses++;
            end
            if (rd && !prev_rd) begin
                if (level < 16 || popped) begin
                    exp_q.push_back(d);
                    level++;
                end else begin
                    model_ovf = 1'b1;
                end
            end
            if (popped) level--;
            prev_rd = rd;
        end
        chk("fifo_count", bus.fifo_count, level);
        chk("fifo_empty", bus.fifo_empty, (level == 0));
        chk("overflow", bus.overflow, model_ovf);
        case (tx_mode)
            0: bus.tx_busy = 1'b0;
            1: bus.tx_busy = 1'b1;
            default: begin
                if (bus.tx_busy && sent_q.size() > 0 && !popped)
                    chk("send_data_stable", bus.send_data, sent_q[$]);
                if (busy_cnt > 0) busy_cnt--;
                if (popped) begin
                    chk("one_in_flight", busy_cnt, 0);
                    busy_cnt = 20;
                end
                bus.tx_busy = (busy_cnt > 0);
            end
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic push(input logic [7:0] b, input int hold);
        bus.recv_data = b;
        bus.recv_done = 1'b1;
        repeat (hold) tick();
        bus.recv_done = 1'b0;
        tick();
    endtask

    task automatic wait_pulses(input string tag, input int n, input int budget);
        int b;
        b = 0;
        while (pulses < n && b < budget) begin
            tick();
            b++;
        end
        chk(tag, pulses, n);
    endtask

    task automatic cmp_seq(input string tag);
        chk({tag, "_len"}, sent_q.size(), exp_q.size());
        for (int i = 0; i < sent_q.size() && i < exp_q.size(); i++)
            chk({tag, "_data"}, sent_q[i], exp_q[i]);
    endtask

    task automatic clear();
        sent_q.delete();
        exp_q.delete();
        pulse_cyc.delete();
        pulses = 0;
    endtask

    initial begin
        sys_rst       = 1'b1;
        bus.recv_done = 1'b0;
        bus.recv_data = 8'h00;
        bus.tx_busy   = 1'b0;

        // reset state
        idle(3);
        chk("rst_count", bus.fifo_count, 0);
        chk("rst_empty", bus.fifo_empty, 1);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_send_en", bus.send_en, 0);
        chk("rst_send_data", bus.send_data, 8'h00);
        sys_rst = 1'b0;
        idle(2);

        // single byte latency
        clear();
        bus.recv_data = 8'hA5;
        bus.recv_done = 1'b1;
        tick();
        chk("single_cnt_n", bus.fifo_count, 1);
        chk("single_en_n", bus.send_en, 0);
        bus.recv_done = 1'b0;
        tick();
        chk("single_en_n1", bus.send_en, 1);
        chk("single_data", bus.send_data, 8'hA5);
        chk("single_cnt_n1", bus.fifo_count, 0);
        tick();
        chk("single_en_n2", bus.send_en, 0);
        idle(15);
        chk("single_pulses", pulses, 1);
        cmp_seq("single");

        // burst with 20-cycle transmitter
        tx_mode  = 2;
        busy_cnt = 0;
        clear();
        for (int i = 1; i <= 16; i++) push(8'(i), 1);
        wait_pulses("burst_pulses", 16, 600);
        idle(30);
        chk("burst_pulses_final", pulses, 16);
        for (int i = 0; i < sent_q.size() && i < 16; i++)
            chk("burst_order", sent_q[i], 8'(i + 1));
        cmp_seq("burst");
        chk("burst_ovf", bus.overflow, 0);

        // randomized bytes, hold lengths and gaps
        clear();
        for (int i = 0; i < 12; i++) begin
            push(8'($urandom_range(0, 255)), $urandom_range(1, 3));
            idle($urandom_range(0, 3));
        end
        wait_pulses("rand_pulses", 12, 800);
        idle(30);
        cmp_seq("rand");

        // overflow with transmitter held busy
        tx_mode     = 1;
        bus.tx_busy = 1'b1;
        clear();
        idle(2);
        for (int i = 0; i < 17; i++) push(8'h20 + 8'(i), 1);
        chk("ovf_count", bus.fifo_count, 16);
        chk("ovf_flag", bus.overflow, 1);
        chk("ovf_no_send", pulses, 0);
        tx_mode     = 2;
        busy_cnt    = 0;
        bus.tx_busy = 1'b0;
        wait_pulses("ovf_pulses", 16, 600);
        idle(40);
        chk("ovf_pulses_final", pulses, 16);
        if (sent_q.size() > 0) chk("ovf_last_byte", sent_q[$], 8'h2F);
        cmp_seq("ovf");
        chk("ovf_sticky", bus.overflow, 1);

        // simultaneous push and pop at full
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        tick();
        tx_mode     = 1;
        bus.tx_busy = 1'b1;
        clear();
        for (int i = 0; i < 16; i++) push(8'h40 + 8'(i), 1);
        chk("full_count", bus.fifo_count, 16);
        tx_mode       = 2;
        busy_cnt      = 0;
        bus.tx_busy   = 1'b0;
        bus.recv_data = 8'h50;
        bus.recv_done = 1'b1;
        tick();
        chk("pp_count", bus.fifo_count, 16);
        chk("pp_ovf", bus.overflow, 0);
        chk("pp_send_en", bus.send_en, 1);
        chk("pp_send_data", bus.send_data, 8'h40);
        bus.recv_done = 1'b0;
        wait_pulses("pp_pulses", 17, 800);
        idle(30);
        cmp_seq("pp");

        // busy timeout: pulses 10 cycles apart when tx_busy never rises
        tx_mode     = 0;
        busy_cnt    = 0;
        bus.tx_busy = 1'b0;
        clear();
        push(8'h60, 1);
        push(8'h61, 1);
        idle(30);
        chk("tmo_pulses", pulses, 2);
        if (pulse_cyc.size() == 2) chk("tmo_interval", pulse_cyc[1] - pulse_cyc[0], 10);
        cmp_seq("tmo");

        // recv_done level held 5 cycles is one push
        clear();
        bus.recv_data = 8'h62;
        bus.recv_done = 1'b1;
        repeat (5) tick();
        bus.recv_done = 1'b0;
        idle(30);
        chk("level_pulses", pulses, 1);
        cmp_seq("level");

        // reset while in WAIT_DONE with 5 bytes queued
        tx_mode  = 2;
        busy_cnt = 0;
        clear();
        for (int i = 0; i < 6; i++) push(8'h70 + 8'(i), 1);
        chk("mid_count", bus.fifo_count, 5);
        chk("mid_pulses", pulses, 1);
        tx_mode = 1;
        sys_rst = 1'b1;
        tick();
        chk("mid_rst_count", bus.fifo_count, 0);
        chk("mid_rst_empty", bus.fifo_empty, 1);
        chk("mid_rst_send_en", bus.send_en, 0);
        chk("mid_rst_send_data", bus.send_data, 8'h00);
        sys_rst     = 1'b0;
        tx_mode     = 0;
        bus.tx_busy = 1'b0;
        pulses      = 0;
        idle(40);
        chk("mid_no_pulses", pulses, 0);
        chk("mid_final_count", bus.fifo_count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_loop_fifo.md
UART_LOOP_FIFO -- requirements
Module: uart_loop_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 4, FIFO depth = 2^DEPTH_LOG2 bytes (16).
REQ-002 Parameter BUSY_TIMEOUT, default 8, max cycles to wait for tx_busy to rise after a launch.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 sys_rst  input  1  reset; synchronous, active-high.
REQ-005 recv_done  input  1  receiver byte-done strobe; only its rising edge is significant.
REQ-006 recv_data  input  8  received byte; valid while recv_done is high.
REQ-007 tx_busy  input  1  transmitter busy, high while a frame is on the line.
REQ-008 send_en  output  1  transmit request, one-cycle pulse.
REQ-009 send_data  output  8  byte to transmit; stable from the send_en pulse until tx_busy falls.
REQ-010 fifo_count  output  DEPTH_LOG2+1  number of stored bytes, range 0..2^DEPTH_LOG2.
REQ-011 fifo_empty  output  1  high when fifo_count == 0.
REQ-012 overflow  output  1  sticky flag; a byte was dropped because the FIFO was full.

Function
REQ-013 The block shall register recv_done each cycle and detect a push at edge N when recv_done is 1 at edge N and was 0 at edge N-1.
- A level held high for several cycles is a single push.
REQ-014 On a push, recv_data shall be written at the write pointer at edge N, and fifo_count shall increment at edge N.
REQ-015 The write and read pointers shall be DEPTH_LOG2 bits wide and wrap modulo 2^DEPTH_LOG2 without any gap.
REQ-016 A push when fifo_count == 2^DEPTH_LOG2 shall be handled as follows:
- the byte is dropped;
- the pointers and count are unchanged;
- overflow is set to 1 and stays set until reset.
REQ-017 A push and a pop in the same cycle shall both take effect, and fifo_count shall be unchanged.
- This also applies when full; the pop frees the slot, so no overflow is flagged.
REQ-018 The send FSM shall have the states IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-019 IDLE: when fifo_count != 0 and tx_busy == 0 at an edge, the FSM shall:
- pop one byte into send_data;
- advance the read pointer;
- go to LAUNCH.
REQ-020 LAUNCH: the FSM shall drive send_en = 1 for exactly this one cycle, then go to WAIT_BUSY.
REQ-021 send_en shall be driven as (state == LAUNCH), with no other source.
REQ-022 WAIT_BUSY: the FSM shall go to WAIT_DONE when tx_busy == 1.
- Otherwise, after BUSY_TIMEOUT cycles in this state, it shall return to IDLE and treat the byte as sent.
REQ-023 WAIT_DONE: the FSM shall go to IDLE when tx_busy == 0.
REQ-024 Latency: for a push detected at edge N with the FIFO empty, FSM in IDLE and tx_busy low:
- the pop occurs at edge N+1;
- send_en is high between edges N+1 and N+2.
REQ-025 The FSM shall never issue a second send_en before the previous byte has completed through WAIT_DONE or timeout, so at most one byte is in flight.
REQ-026 Bytes shall be transmitted in arrival order with no duplication.
REQ-027 send_data shall change only at a pop.

Reset
REQ-028 When sys_rst is high at an edge, the block shall:
- clear both pointers and fifo_count to 0;
- set fifo_empty = 1;
- clear overflow to 0;
- force state to IDLE;
- set send_en = 0 and send_data = 8'h00;
- clear the recv_done history register to 0.
REQ-029 Reset mid-operation (any state, any count) shall take effect at that edge and discard all stored and in-flight bytes.
REQ-030 The first push after release is detected only from a fresh recv_done rising edge.
- recv_done already high at release counts as a rising edge at the first edge after release.

Verification
REQ-031 Single byte: push 8'hA5 at edge N, tx_busy held low -> pop at N+1, send_en pulse one cycle, send_data = 8'hA5, fifo_count returns to 0.
REQ-032 Burst and ordering: push 8'h01..8'h10 back-to-back while tx_busy is modelled at 20 cycles per byte -> 16 send_en pulses, data 01..10 in order, overflow = 0.
REQ-033 Overflow: hold tx_busy high, push 17 bytes 8'h20..8'h30 -> fifo_count = 16 and overflow = 1; after releasing tx_busy, 20..2F are sent and 30 is absent.
REQ-034 Simultaneous push and pop at full count 16 -> count stays 16 and overflow stays 0.
REQ-035 Timeout and level: tx_busy never rises after launch -> IDLE after 8 cycles and the next byte proceeds; recv_done held high for 5 cycles -> exactly one push.
REQ-036 Reset in WAIT_DONE with 5 bytes queued -> next edge: count 0, state IDLE, send_en 0, send_data 8'h00, no further pulses.
